// File: rtl/step_move_sched.sv
// ---------------------------------------------------------------------------
// step_move_sched
// Motion scheduler in front of the step-motor phase sequencer. Accepts move
// commands over valid/ready, emits one-cycle step pulses at the commanded
// period, holds a settle dwell after a direction change, supports abort and
// reports progress (steps_left) and completion (done/aborted).
//
// Optional build macro: STEP_MOVE_SCHED_ACCEL_EN
//   defined   -> trapezoidal ramp (start slow, speed up over the first R steps,
//                slow down over the last R steps)
//   undefined -> constant step period
//
// Ports:
//   clk         system clock, rising edge
//   rest        asynchronous active-high reset
//   cmd_valid   command offered
//   cmd_ready   command can be accepted (IDLE only)
//   cmd_steps   number of steps to issue
//   cmd_dir     direction (1 = forward)
//   cmd_period  clk cycles between step pulses (clamped to MIN_PERIOD)
//   abort       terminate the current move (ignored in IDLE/DONE)
//   step        one-cycle step pulse
//   dir_out     registered direction
//   busy        high while settling or running
//   steps_left  steps still to issue
//   done        one-cycle pulse at the end of every accepted move
//   aborted     valid with done; 1 if the move ended by abort
// ---------------------------------------------------------------------------
module step_move_sched #(
    parameter int CNT_W      = 16,
    parameter int DIV_W      = 20,
    parameter int MIN_PERIOD = 4,
    parameter int SETTLE_CYC = 1000,
    parameter int RAMP_DELTA = 2,
    parameter int RAMP_STEPS = 8
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step,
    output logic             dir_out,
    output logic             busy,
    output logic [CNT_W-1:0] steps_left,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);
    localparam logic [DIV_W-1:0] MIN_P       = DIV_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [DIV_W-1:0]   period_r;
    logic [DIV_W-1:0]   cur_period_s;
    logic [DIV_W-1:0]   cnt_r;
    logic [SET_W-1:0]   settle_cnt_r;
    logic [DIV_W-1:0]   clamped_s;
    logic               accept_s;
    logic               step_due_s;
    logic               step_fire_s;
    logic               last_step_s;
    logic               abort_end_s;

    assign accept_s    = (state_r == ST_IDLE) && cmd_ready && cmd_valid;
    assign clamped_s   = (cmd_period < MIN_P) ? MIN_P : cmd_period;
    assign step_due_s  = (state_r == ST_RUN) && (cnt_r == (cur_period_s - DIV_W'(1)));
    // An abort that coincides with a due step wins: the step is dropped.
    assign step_fire_s = step_due_s && !abort && (steps_left != CNT_ZERO);
    // The final step is on the wire this cycle; the move is complete.
    assign last_step_s = (state_r == ST_RUN) && step && (steps_left == CNT_ZERO);

`ifdef STEP_MOVE_SCHED_ACCEL_EN
    localparam logic [DIV_W-1:0] DELTA  = DIV_W'(RAMP_DELTA);
    localparam logic [CNT_W-1:0] RSTEPS = CNT_W'(RAMP_STEPS);

    logic [DIV_W-1:0] cur_period_r;
    logic [CNT_W-1:0] ramp_r;
    logic [CNT_W-1:0] total_r;
    logic [CNT_W-1:0] half_s;
    logic [CNT_W-1:0] ramp_s;
    logic [CNT_W-1:0] issued_s;

    assign half_s   = cmd_steps >> 1;
    assign ramp_s   = (half_s < RSTEPS) ? half_s : RSTEPS;
    // Number of steps issued once the step firing now has gone out.
    assign issued_s = total_r - steps_left + CNT_W'(1);

    // Ramp state: active period, ramp length and total move length.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            cur_period_r <= {DIV_W{1'b0}};
            ramp_r       <= CNT_ZERO;
            total_r      <= CNT_ZERO;
        end else if (accept_s) begin
            cur_period_r <= clamped_s + (DELTA * DIV_W'(ramp_s));
            ramp_r       <= ramp_s;
            total_r      <= cmd_steps;
        end else if (step_fire_s) begin
            if (issued_s <= ramp_r) begin
                // Accelerating; never drop below the commanded period.
                if (cur_period_r >= (period_r + DELTA)) begin
                    cur_period_r <= cur_period_r - DELTA;
                end else begin
                    cur_period_r <= period_r;
                end
            end else if ((steps_left - CNT_W'(1)) <= ramp_r) begin
                cur_period_r <= cur_period_r + DELTA;
            end else begin
                cur_period_r <= cur_period_r;
            end
        end else begin
            cur_period_r <= cur_period_r;
        end
    end

    assign cur_period_s = cur_period_r;
`else
    assign cur_period_s = period_r;
`endif

    // Next-state decode; also flags when DONE is entered because of abort.
    always_comb begin
        state_nxt_s = state_r;
        abort_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cmd_steps == CNT_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else if (cmd_dir != dir_out) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt_s = ST_DONE;
                    abort_end_s = 1'b1;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_RUN: begin
                // Natural completion takes precedence over a late abort.
                if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else if (abort) begin
                    state_nxt_s = ST_DONE;
                    abort_end_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_r      <= ST_IDLE;
            period_r     <= {DIV_W{1'b0}};
            cnt_r        <= {DIV_W{1'b0}};
            settle_cnt_r <= {SET_W{1'b0}};
            cmd_ready    <= 1'b1;
            step         <= 1'b0;
            dir_out      <= 1'b0;
            busy         <= 1'b0;
            steps_left   <= CNT_ZERO;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cmd_ready <= (state_nxt_s == ST_IDLE);
            busy      <= (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_RUN);
            done      <= (state_nxt_s == ST_DONE);
            aborted   <= abort_end_s;
            step      <= step_fire_s;

            if (accept_s) begin
                steps_left <= cmd_steps;
                period_r   <= clamped_s;
                // A zero-length move leaves the direction line alone.
                if (cmd_steps != CNT_ZERO) begin
                    dir_out <= cmd_dir;
                end else begin
                    dir_out <= dir_out;
                end
            end else if (step_fire_s) begin
                steps_left <= steps_left - CNT_W'(1);
            end else begin
                steps_left <= steps_left;
            end

            // Period counter restarts at 0 on RUN entry and after each due step.
            if ((state_r != ST_RUN) || (state_nxt_s != ST_RUN) || step_due_s) begin
                cnt_r <= {DIV_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + DIV_W'(1);
            end

            if ((state_r == ST_SETTLE) && (state_nxt_s == ST_SETTLE)) begin
                settle_cnt_r <= settle_cnt_r + SET_W'(1);
            end else begin
                settle_cnt_r <= {SET_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_step_move_sched.sv
// ---------------------------------------------------------------------------
// tb_step_move_sched
// Directed bench for step_move_sched with hand-computed step/done timing.
// Cycle numbering: cyc increments at every rising edge; E is the first cycle
// after the accept edge (RUN/SETTLE/DONE entry).
// ---------------------------------------------------------------------------
module tb_step_move_sched;

    logic        clk;
    logic        rest;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [19:0] cmd_period;
    logic        abort;
    logic        step;
    logic        dir_out;
    logic        busy;
    logic [15:0] steps_left;
    logic        done;
    logic        aborted;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int step_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_ab  = 1'b0;
    logic done_rdy = 1'b0;
    int e;

    step_move_sched dut (
        .clk        (clk),
        .rest       (rest),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step       (step),
        .dir_out    (dir_out),
        .busy       (busy),
        .steps_left (steps_left),
        .done       (done),
        .aborted    (aborted)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Output monitor sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (step) step_q.push_back(cyc);
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                done_ab  = aborted;
                done_rdy = cmd_ready;
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one command; returns E, the first cycle after the accept edge.
    task automatic issue(input string tag, input logic [15:0] s, input logic d,
                         input logic [19:0] p, output int entry);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_steps  = s;
        cmd_dir    = d;
        cmd_period = p;
        cmd_valid  = 1'b1;
        step_q.delete();
        done_cnt   = 0;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        entry      = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check({tag, "_done_seen"}, done_cnt, 32'd1);
    endtask

    // done timing/flag, cmd_ready low with done and high the cycle after
    task automatic check_done_tail(input string tag, input int exp_cyc, input logic exp_ab);
        check({tag, "_done_cyc"}, done_cyc, exp_cyc);
        check({tag, "_aborted"}, {31'd0, done_ab}, {31'd0, exp_ab});
        check({tag, "_rdy_at_done"}, {31'd0, done_rdy}, 32'd0);
        while (cyc < done_cyc + 1) @(negedge clk);
        check({tag, "_rdy_after"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        rest       = 1'b1;
        cmd_valid  = 1'b0;
        cmd_steps  = 16'd0;
        cmd_dir    = 1'b0;
        cmd_period = 20'd0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_dir", {31'd0, dir_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_left", {16'd0, steps_left}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_aborted", {31'd0, aborted}, 32'd0);
        rest = 1'b0;

        // T1: 3 steps, same direction, period 10 -> RUN directly
        issue("t1", 16'd3, 1'b0, 20'd10, e);
        check("t1_left_entry", {16'd0, steps_left}, 32'd3);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready_low", {31'd0, cmd_ready}, 32'd0);
        wait_done("t1", 200);
        check("t1_nsteps", step_q.size(), 32'd3);
        check("t1_step1", step_q[0], e + 10);
        check("t1_step2", step_q[1], e + 20);
        check("t1_step3", step_q[2], e + 30);
        check_done_tail("t1", e + 31, 1'b0);
        check("t1_left_end", {16'd0, steps_left}, 32'd0);

        // T2: direction change -> 1000-cycle settle, then period 5
        issue("t2", 16'd2, 1'b1, 20'd5, e);
        check("t2_dir", {31'd0, dir_out}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd1);
        wait_done("t2", 1200);
        check("t2_nsteps", step_q.size(), 32'd2);
        check("t2_step1", step_q[0], e + 1005);
        check("t2_step2", step_q[1], e + 1010);
        check_done_tail("t2", e + 1011, 1'b0);

        // T3: zero-step move, other direction requested -> dir_out unchanged
        issue("t3", 16'd0, 1'b0, 20'd7, e);
        wait_done("t3", 20);
        check("t3_nsteps", step_q.size(), 32'd0);
        check("t3_dir", {31'd0, dir_out}, 32'd1);
        check_done_tail("t3", e, 1'b0);

        // T4: period 1 clamped to 4
        issue("t4", 16'd3, 1'b1, 20'd1, e);
        wait_done("t4", 100);
        check("t4_nsteps", step_q.size(), 32'd3);
        check("t4_step1", step_q[0], e + 4);
        check("t4_step2", step_q[1], e + 8);
        check("t4_step3", step_q[2], e + 12);
        check_done_tail("t4", e + 13, 1'b0);

        // T5: 10 steps period 8; abort in the cycle the 4th step falls due
        issue("t5", 16'd10, 1'b1, 20'd8, e);
        while (cyc < e + 31) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("t5", 50);
        check("t5_nsteps", step_q.size(), 32'd3);
        check_done_tail("t5", e + 32, 1'b1);
        check("t5_left", {16'd0, steps_left}, 32'd7);

        // T6: reset mid-RUN at steps_left == 5
        issue("t6", 16'd10, 1'b1, 20'd4, e);
        begin
            int n;
            n = 0;
            while (steps_left != 16'd5 && n < 200) begin
                @(negedge clk);
                n = n + 1;
            end
        end
        check("t6_reach5", {16'd0, steps_left}, 32'd5);
        rest = 1'b1;
        #1;
        check("t6_rst_step", {31'd0, step}, 32'd0);
        check("t6_rst_left", {16'd0, steps_left}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_dir", {31'd0, dir_out}, 32'd0);
        check("t6_rst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rest = 1'b0;
        step_q.delete();
        done_cnt = 0;
        repeat (20) @(negedge clk);
        check("t6_no_step", step_q.size(), 32'd0);
        check("t6_no_done", done_cnt, 32'd0);
        issue("t6b", 16'd2, 1'b0, 20'd4, e);
        wait_done("t6b", 50);
        check("t6b_nsteps", step_q.size(), 32'd2);
        check("t6b_step1", step_q[0], e + 4);
        check("t6b_step2", step_q[1], e + 8);
        check_done_tail("t6b", e + 9, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
